wr_burst_reader: RTL and testbench

WR_BURST_READER -- requirements
Module: wr_burst_reader

---
 rtl/wr_burst_reader_pkg.sv | 22 ++
 rtl/wr_burst_beat_cnt.sv | 30 +++
 rtl/wr_burst_reader.sv | 182 ++++++++++++++++++
 tb/tb_wr_burst_reader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_burst_reader_pkg.sv
// Shared types and constants for the frame-to-AXI write burst reader.
package wr_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned BITS_PER_BYTE = 8;

    function automatic int unsigned bytes_per_beat(input int unsigned data_width);
        return data_width / BITS_PER_BYTE;
    endfunction

endpackage

// File: rtl/wr_burst_beat_cnt.sv
// Beat counter for one AXI write burst; flags the beat whose index equals awlen.
module wr_burst_beat_cnt
    import wr_burst_reader_pkg::*;
(
    input  logic       rd_clk,
    input  logic       rd_rst,
    input  logic       clr,
    input  logic       beat_xfer,
    input  logic [7:0] burst_len_m1,
    output logic       last_beat
);

    logic [7:0] cnt_r;

    // count accepted beats, restarting from zero while the address phase is open
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (beat_xfer) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last_beat = (cnt_r == burst_len_m1);

endmodule

// File: rtl/wr_burst_reader.sv
// Drains a prefetch FIFO into a frame buffer as a sequence of AXI write bursts.
module wr_burst_reader
    import wr_burst_reader_pkg::*;
#(
    parameter int c_DATA_WIDTH  = 32,
    parameter int c_ADDR_WIDTH  = 28,
    parameter int c_BURST_LEN   = 16,
    parameter int c_FRAME_WIDTH = 22
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    input  logic [c_DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                     fifo_rd_vld,
    output logic                     fifo_rd_en,
    input  logic [c_ADDR_WIDTH-1:0]  base_addr,
    input  logic [c_FRAME_WIDTH-1:0] frame_words,
    input  logic                     frame_start,
    output logic [c_ADDR_WIDTH-1:0]  m_awaddr,
    output logic [7:0]               m_awlen,
    output logic                     m_awvalid,
    input  logic                     m_awready,
    output logic [c_DATA_WIDTH-1:0]  m_wdata,
    output logic                     m_wlast,
    output logic                     m_wvalid,
    input  logic                     m_wready,
    input  logic [1:0]               m_bresp,
    input  logic                     m_bvalid,
    output logic                     m_bready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     resp_err
);

    localparam int unsigned C_BEAT_BYTES = bytes_per_beat(c_DATA_WIDTH);

    state_e                   state_r, state_n;
    logic [c_ADDR_WIDTH-1:0]  addr_r, addr_n, addr_step_s;
    logic [c_FRAME_WIDTH-1:0] remain_r, remain_n, remain_step_s;
    logic [7:0]               awlen_r, awlen_n;
    logic [8:0]               beats_s;
    logic                     pend_r, pend_n;
    logic                     frame_done_r, done_n;
    logic                     resp_err_r, err_n;
    logic                     final_s, restart_s, beat_xfer_s, last_beat_s, clr_s;

    function automatic logic [7:0] len_m1(input logic [c_FRAME_WIDTH-1:0] words);
        if (words >= c_FRAME_WIDTH'(c_BURST_LEN)) begin
            return 8'(c_BURST_LEN - 1);
        end else begin
            return 8'(words - c_FRAME_WIDTH'(1));
        end
    endfunction

    // Handshake qualifiers drop during reset so an abandoned burst never pops the FIFO.
    assign m_awvalid   = (state_r == ST_ADDR) & ~rd_rst;
    assign m_wvalid    = (state_r == ST_DATA) & fifo_rd_vld & ~rd_rst;
    assign fifo_rd_en  = (state_r == ST_DATA) & m_wready & ~rd_rst;
    assign m_bready    = (state_r == ST_RESP) & ~rd_rst;
    assign m_wlast     = (state_r == ST_DATA) & last_beat_s & ~rd_rst;
    assign m_wdata     = fifo_rd_data;
    assign m_awaddr    = addr_r;
    assign m_awlen     = awlen_r;
    assign busy        = (state_r != ST_IDLE);
    assign frame_done  = frame_done_r;
    assign resp_err    = resp_err_r;

    assign beat_xfer_s   = m_wvalid & m_wready;
    assign clr_s         = (state_r == ST_ADDR);
    assign beats_s       = {1'b0, awlen_r} + 9'd1;
    assign addr_step_s   = addr_r + (c_ADDR_WIDTH'(beats_s) * c_ADDR_WIDTH'(C_BEAT_BYTES));
    assign remain_step_s = remain_r - c_FRAME_WIDTH'(beats_s);
    assign final_s       = (remain_r == c_FRAME_WIDTH'(beats_s));
    assign restart_s     = pend_r | frame_start;

    wr_burst_beat_cnt u_beat_cnt (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .clr          (clr_s),
        .beat_xfer    (beat_xfer_s),
        .burst_len_m1 (awlen_r),
        .last_beat    (last_beat_s)
    );

    // next-state and datapath updates for the burst sequencer
    always_comb begin
        state_n  = state_r;
        addr_n   = addr_r;
        remain_n = remain_r;
        awlen_n  = awlen_r;
        pend_n   = pend_r;
        done_n   = 1'b0;
        err_n    = resp_err_r;

        // A restart outside IDLE waits for the current burst's response.
        if (frame_start && (state_r != ST_IDLE) && !((state_r == ST_RESP) && m_bvalid)) begin
            pend_n = 1'b1;
        end else begin
            pend_n = pend_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_n  = ST_ADDR;
                    addr_n   = base_addr;
                    remain_n = frame_words;
                    awlen_n  = len_m1(frame_words);
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (m_awready) begin
                    state_n = ST_DATA;
                end else begin
                    state_n = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (beat_xfer_s && last_beat_s) begin
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_RESP: begin
                if (m_bvalid) begin
                    if (m_bresp != RESP_OKAY) begin
                        err_n = 1'b1;
                    end else begin
                        err_n = resp_err_r;
                    end
                    if (restart_s) begin
                        state_n  = ST_ADDR;
                        addr_n   = base_addr;
                        remain_n = frame_words;
                        awlen_n  = len_m1(frame_words);
                        pend_n   = 1'b0;
                        done_n   = final_s & ~pend_r;
                    end else if (final_s) begin
                        state_n  = ST_IDLE;
                        addr_n   = addr_step_s;
                        remain_n = remain_step_s;
                        done_n   = 1'b1;
                    end else begin
                        state_n  = ST_ADDR;
                        addr_n   = addr_step_s;
                        remain_n = remain_step_s;
                        awlen_n  = len_m1(remain_step_s);
                    end
                end else begin
                    state_n = ST_RESP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // sequencer state and datapath registers
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_r      <= ST_IDLE;
            addr_r       <= '0;
            remain_r     <= '0;
            awlen_r      <= 8'd0;
            pend_r       <= 1'b0;
            frame_done_r <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_n;
            addr_r       <= addr_n;
            remain_r     <= remain_n;
            awlen_r      <= awlen_n;
            pend_r       <= pend_n;
            frame_done_r <= done_n;
            resp_err_r   <= err_n;
        end
    end

endmodule

// File: tb/tb_wr_burst_reader.sv
// Scoreboard bench for wr_burst_reader: expected AW/W traffic is queued as frames are launched.
module tb_wr_burst_reader;

    localparam int DW = 32;
    localparam int AW = 28;
    localparam int BL = 16;
    localparam int FW = 22;

    logic          rd_clk;
    logic          rd_rst;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_vld;
    logic          fifo_rd_en;
    logic [AW-1:0] base_addr;
    logic [FW-1:0] frame_words;
    logic          frame_start;
    logic [AW-1:0] m_awaddr;
    logic [7:0]    m_awlen;
    logic          m_awvalid, m_awready;
    logic [DW-1:0] m_wdata;
    logic          m_wlast, m_wvalid, m_wready;
    logic [1:0]    m_bresp;
    logic          m_bvalid, m_bready;
    logic          busy, frame_done, resp_err;

    typedef struct packed {logic [AW-1:0] addr; logic [7:0] len;} aw_t;
    typedef struct packed {logic [DW-1:0] data; logic last;} w_t;

    aw_t aw_q[$];
    w_t  w_q[$];

    int n_vec = 0;
    int n_err = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0;
    int err_idx = -1;
    bit wr_toggle = 1'b0;
    logic [DW-1:0] exp_data = '0;

    wr_burst_reader #(.c_DATA_WIDTH(DW), .c_ADDR_WIDTH(AW), .c_BURST_LEN(BL), .c_FRAME_WIDTH(FW)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(fifo_rd_en),
        .base_addr(base_addr), .frame_words(frame_words), .frame_start(frame_start),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy(busy), .frame_done(frame_done), .resp_err(resp_err)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_bursts(input logic [AW-1:0] base, input int words, input int max_b);
        logic [AW-1:0] a;
        int rem;
        int nb;
        int len;
        aw_t e;
        w_t  d;
        a = base;
        rem = words;
        nb = 0;
        while (rem > 0 && nb < max_b) begin
            len = (rem >= BL) ? BL : rem;
            e.addr = a;
            e.len  = 8'(len - 1);
            aw_q.push_back(e);
            for (int i = 0; i < len; i++) begin
                d.data = exp_data;
                d.last = (i == len - 1);
                w_q.push_back(d);
                exp_data = exp_data + 1;
            end
            a = a + AW'(len * (DW / 8));
            rem -= len;
            nb++;
        end
    endtask

    task automatic start_frame(input logic [AW-1:0] base, input int words);
        @(posedge rd_clk); #1;
        base_addr   = base;
        frame_words = FW'(words);
        frame_start = 1'b1;
        @(posedge rd_clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int t;
        t = 0;
        while (done_cnt < target && t < 3000) begin
            @(posedge rd_clk);
            t++;
        end
        check_eq({tag, "_done"}, 64'(done_cnt), 64'(target));
        repeat (4) @(posedge rd_clk);
        #3;
        check_eq({tag, "_done_once"}, 64'(done_cnt), 64'(target));
        check_eq({tag, "_aw_left"}, 64'(aw_q.size()), 64'd0);
        check_eq({tag, "_w_left"}, 64'(w_q.size()), 64'd0);
        check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // slave and FIFO model: observe at negedge, respond just after posedge
    initial begin : bfm
        bit aw_hs, w_hs, wl_hs, b_hs, pop;
        aw_t a;
        w_t  w;
        m_wready = 1'b1;
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
        fifo_rd_data = '0;
        forever begin
            @(negedge rd_clk);
            aw_hs = m_awvalid & m_awready;
            w_hs  = m_wvalid & m_wready;
            wl_hs = w_hs & m_wlast;
            b_hs  = m_bvalid & m_bready;
            pop   = fifo_rd_vld & fifo_rd_en;
            if (m_wvalid) check_eq("rd_en_eq_wready", 64'(fifo_rd_en), 64'(m_wready));
            if (pop || w_hs) check_eq("pop_eq_beat", 64'(pop), 64'(w_hs));
            if (aw_hs) begin
                aw_cnt++;
                if (aw_q.size() == 0) begin
                    check_eq("aw_unexpected", 64'(m_awaddr), 64'hFFFF_FFFF);
                end else begin
                    a = aw_q.pop_front();
                    check_eq("awaddr", 64'(m_awaddr), 64'(a.addr));
                    check_eq("awlen", 64'(m_awlen), 64'(a.len));
                end
            end
            if (w_hs) begin
                w_cnt++;
                if (w_q.size() == 0) begin
                    check_eq("w_unexpected", 64'(m_wdata), 64'hFFFF_FFFF_FFFF);
                end else begin
                    w = w_q.pop_front();
                    check_eq("wdata", 64'(m_wdata), 64'(w.data));
                    check_eq("wlast", 64'(m_wlast), 64'(w.last));
                end
            end
            if (frame_done === 1'b1) done_cnt++;
            @(posedge rd_clk); #1;
            if (pop) fifo_rd_data = fifo_rd_data + 1;
            m_wready = wr_toggle ? ~m_wready : 1'b1;
            if (b_hs) begin
                m_bvalid = 1'b0;
                m_bresp  = 2'b00;
                b_cnt++;
            end
            if (wl_hs) begin
                m_bvalid = 1'b1;
                m_bresp  = (b_cnt == err_idx) ? 2'b10 : 2'b00;
            end
        end
    end

    initial begin : main
        int t, a0, w0, d0, b0;
        rd_rst      = 1'b1;
        fifo_rd_vld = 1'b1;
        m_awready   = 1'b1;
        frame_start = 1'b0;
        base_addr   = '0;
        frame_words = '0;
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_awaddr", 64'(m_awaddr), 64'd0);
        check_eq("rst_awlen", 64'(m_awlen), 64'd0);
        check_eq("rst_awvalid", 64'(m_awvalid), 64'd0);
        check_eq("rst_bready", 64'(m_bready), 64'd0);
        check_eq("rst_done", 64'(frame_done), 64'd0);
        check_eq("rst_err", 64'(resp_err), 64'd0);
        check_eq("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        @(posedge rd_clk); #1;
        rd_rst = 1'b0;

        // basic 40-word frame: 16 + 16 + 8
        a0 = aw_cnt; w0 = w_cnt;
        push_bursts(28'h1000, 40, 99);
        start_frame(28'h1000, 40);
        wait_done(1, "basic");
        check_eq("basic_bursts", 64'(aw_cnt - a0), 64'd3);
        check_eq("basic_pops", 64'(w_cnt - w0), 64'd40);
        check_eq("basic_err", 64'(resp_err), 64'd0);

        // FIFO empty for 5 cycles mid-burst
        w0 = w_cnt;
        push_bursts(28'h3000, 32, 99);
        start_frame(28'h3000, 32);
        t = 0;
        while (w_cnt < w0 + 5 && t < 500) begin
            @(posedge rd_clk);
            t++;
        end
        #1;
        fifo_rd_vld = 1'b0;
        w0 = w_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge rd_clk); #1;
            end
            #2;
            check_eq("gap_wvalid", 64'(m_wvalid), 64'd0);
        end
        @(posedge rd_clk); #1;
        fifo_rd_vld = 1'b1;
        check_eq("gap_no_pops", 64'(w_cnt), 64'(w0));
        wait_done(2, "gap");

        // m_wready toggling every cycle
        wr_toggle = 1'b1;
        push_bursts(28'h4000, 20, 99);
        start_frame(28'h4000, 20);
        wait_done(3, "toggle");
        wr_toggle = 1'b0;

        // restart during burst 2 of 3
        a0 = aw_cnt; d0 = done_cnt;
        push_bursts(28'h1000, 40, 2);
        push_bursts(28'h8000, 20, 99);
        start_frame(28'h1000, 40);
        t = 0;
        while (aw_cnt < a0 + 2 && t < 500) begin
            @(posedge rd_clk);
            t++;
        end
        check_eq("abort_reach_b2", 64'(aw_cnt >= a0 + 2), 64'd1);
        start_frame(28'h8000, 20);
        wait_done(d0 + 1, "abort");
        check_eq("abort_bursts", 64'(aw_cnt - a0), 64'd4);

        // SLVERR on the first burst of a frame
        b0 = b_cnt;
        err_idx = b0;
        push_bursts(28'h5000, 48, 99);
        start_frame(28'h5000, 48);
        t = 0;
        while (b_cnt < b0 + 1 && t < 500) begin
            @(posedge rd_clk);
            t++;
        end
        #3;
        check_eq("err_set", 64'(resp_err), 64'd1);
        wait_done(5, "err");
        check_eq("err_sticky", 64'(resp_err), 64'd1);
        err_idx = -1;

        // reset after 3 beats of a burst
        w0 = w_cnt;
        push_bursts(28'h6000, 16, 99);
        start_frame(28'h6000, 16);
        t = 0;
        while (w_cnt < w0 + 3 && t < 500) begin
            @(posedge rd_clk);
            t++;
        end
        #1;
        rd_rst = 1'b1;
        #2;
        check_eq("rstmid_rd_en", 64'(fifo_rd_en), 64'd0);
        check_eq("rstmid_wvalid", 64'(m_wvalid), 64'd0);
        @(posedge rd_clk); #1;
        rd_rst = 1'b0;
        #2;
        check_eq("rstmid_busy", 64'(busy), 64'd0);
        check_eq("rstmid_awaddr", 64'(m_awaddr), 64'd0);
        check_eq("rstmid_awlen", 64'(m_awlen), 64'd0);
        check_eq("rstmid_wlast", 64'(m_wlast), 64'd0);
        check_eq("rstmid_bready", 64'(m_bready), 64'd0);
        check_eq("rstmid_err", 64'(resp_err), 64'd0);
        check_eq("rstmid_leftover", 64'(w_q.size()), 64'd13);
        w0 = w_cnt;
        repeat (5) @(posedge rd_clk);
        check_eq("rstmid_no_pops", 64'(w_cnt), 64'(w0));
        aw_q.delete();
        w_q.delete();
        exp_data = exp_data - 13;
        push_bursts(28'h2000, 8, 99);
        start_frame(28'h2000, 8);
        wait_done(6, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
